// File: rtl/imem_loader_if.sv
// Host boot-load port for imem_loader: valid/ready word stream plus restart pulse.
interface imem_loader_if;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_start;

  modport master (output ld_valid, output ld_data, output ld_start, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_start, output ld_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with zero-latency fetch read and a host-driven boot loader
// that holds the core in reset until the announced program length has been consumed.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        IMAddress,
  output logic [15:0]        instr,
  imem_loader_if.slave       ld,
  output logic               core_reset,
  output logic               ld_error,
  output logic [AW:0]        loaded_count
);

  typedef enum logic [1:0] {WAIT_HDR, LOAD, RUN} state_t;

  localparam logic [15:0] K_DEPTH = 16'(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] k_q, k_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        fire;
  logic [15:0] mem_q [DEPTH];

  assign ld.ld_ready = (state_q != RUN);
  assign fire        = ld.ld_valid & ld.ld_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      WAIT_HDR: begin
        if (fire) begin
          n_d     = ld.ld_data;
          k_d     = '0;
          state_d = (ld.ld_data == 16'd0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (fire) begin
          // Words past DEPTH are still consumed so the host stream stays in step.
          if (k_q < K_DEPTH) begin
            mem_we = 1'b1;
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          k_d = k_q + 16'd1;
          if (k_q == n_q - 16'd1) state_d = RUN;
        end
      end
      RUN: begin
        if (ld.ld_start) begin
          state_d = WAIT_HDR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = WAIT_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_HDR;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; stale contents are hidden by the loaded_count bound.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[k_q[AW-1:0]] <= ld.ld_data;
  end

  always_comb begin
    instr = 16'h0000;
    if (IMAddress < 16'(cnt_q)) instr = mem_q[IMAddress[AW-1:0]];
  end

  assign core_reset   = reset | (state_q != RUN);
  assign ld_error     = err_q;
  assign loaded_count = cnt_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the single-cycle core: answers the fetch unit's 16-bit instruction address with the instruction word in the same cycle. Also owns the boot path. A host streams a length header plus program words over a valid/ready port. The block fills memory from address 0 and holds the core in reset until the load completes, so the PC starts fetching at 0.

## Interface
Parameters:
- DEPTH, 256, number of 16-bit instruction words stored.
- AW, 8, index width; DEPTH = 2**AW.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- IMAddress  input  16  fetch address from the fetch unit.
- instr  output  16  instruction word for IMAddress; combinational.
- ld_valid  input  1  host has a load word on ld_data.
- ld_data  input  16  header or program word.
- ld_ready  output  1  block accepts ld_data this cycle.
- ld_start  input  1  single-cycle pulse in RUN that restarts the boot load.
- core_reset  output  1  reset for the fetch unit and the rest of the core.
- ld_error  output  1  sticky flag: header count exceeded DEPTH.
- loaded_count  output  AW+1  number of words written, 0..DEPTH.

## Operation
- **Transfer rule:** a word is transferred on a rising edge where ld_valid and ld_ready are both 1. The host may hold ld_valid with stable data for any number of cycles.
- **States:** WAIT_HDR, LOAD, RUN.
- **WAIT_HDR:** ld_ready=1. The transferred word is latched as count N (16-bit, unsigned).
  - N=0: go to RUN.
  - N>0: go to LOAD with index k=0.
- **LOAD:** ld_ready=1. Each transferred word is handled at index k, then k increments.
  - If k<DEPTH: write mem[k] and increment loaded_count.
  - If k≥DEPTH: discard the word and set ld_error.
  - After the word with k=N-1 is transferred, go to RUN.
- **RUN:** ld_ready=0, core_reset=0. A ld_start pulse does all of the following:
  - moves to WAIT_HDR;
  - clears loaded_count and ld_error.
  - Memory contents are not cleared.
  - ld_start is ignored in WAIT_HDR and LOAD.
- **core_reset:** equals reset OR (state ≠ RUN).
- **instr:**
  - If IMAddress < loaded_count (zero-extended compare), instr = mem[IMAddress[AW-1:0]].
  - Otherwise instr = 16'h0000. This covers out-of-range addresses and unloaded words.
- **Counter widths:**
  - k is 16-bit, so N up to 65535 is honoured and excess words are still consumed.
  - loaded_count saturates at DEPTH.
- **Reset:** synchronous, and it overrides everything, including mid-load.
  - Next state is WAIT_HDR.
  - loaded_count=0, ld_error=0, k=0.
  - Memory is retained but unreadable, because loaded_count=0.

## Timing
- Reset values:
  - core_reset=1 and ld_ready=1 (state WAIT_HDR).
  - ld_error=0, loaded_count=0, so instr=0.
- **Read latency:** instr is valid in the same cycle as IMAddress (zero-cycle latency).
- **Write latency:**
  - A word transferred at edge t is visible on instr from cycle t+1.
  - A read of the same index in cycle t returns the old value (0, since loaded_count has not yet grown).
- **Load throughput:** one word per cycle. A load of N words takes N+1 transfers.
- **core_reset release:** core_reset falls in the cycle after the edge that transfers the last word (or the header, when N=0).
  - The fetch unit leaves reset on the following edge with PC=0, and mem[0] is already readable.
- **ld_start in RUN:**
  - core_reset rises and ld_ready rises in the next cycle.
  - A ld_valid asserted in the same cycle as ld_start is not transferred, because ld_ready=0 in RUN.
- **ld_error timing:** ld_error rises in the cycle after the transfer with k=DEPTH and stays high until reset or ld_start.

## Test plan
- **Normal load:** reset, then header 3 and words 16'h1111, 16'h2222, 16'h3333 on back-to-back cycles.
  - core_reset falls one cycle after the last word.
  - loaded_count=3; IMAddress 0/1/2 give 1111/2222/3333.
  - IMAddress 3 gives 0000.
- **Stalled host:** same load with ld_valid low for 2 cycles between each word.
  - Identical final memory and count.
  - core_reset stays 1 until the last transfer.
- **Zero length:** header 0.
  - core_reset falls one cycle after the header.
  - loaded_count=0; instr=0 for any IMAddress.
- **Overflow (DEPTH=4):** header 6 plus words A..F.
  - mem[0..3]=A..D; E and F are consumed and discarded.
  - ld_error=1, loaded_count=4, RUN after F.
  - IMAddress 16'h0104 gives 0.
- **Reset mid-load:** assert reset after 2 of 5 words.
  - State WAIT_HDR, loaded_count=0, instr=0, core_reset=1.
  - A fresh header 1 plus word 16'hBEEF gives instr(0)=BEEF.
- **Reload:** in RUN, pulse ld_start together with ld_valid.
  - That word is not transferred; core_reset=1 and ld_ready=1 in the next cycle.
  - A new header 1 plus word 16'h00AA gives loaded_count=1 and instr(1)=0.
